// File: rtl/ntt_mem_sequencer_pkg.sv
// ntt_seq_pkg: shared definitions for the NTT memory sequencer.
// Holds the command mode codes, the command record pushed through the
// command FIFO, and the sequencer FSM state encoding.
package ntt_seq_pkg;

    localparam logic [1:0] MODE_NTT    = 2'd0;
    localparam logic [1:0] MODE_INTT   = 2'd1;
    localparam logic [1:0] MODE_MULT   = 2'd2;
    localparam logic [1:0] MODE_ADDSUB = 2'd3;

    localparam int OFF_W = 9;

    // One queued command: everything the processor needs held for a run.
    typedef struct packed {
        logic [1:0]       mode;
        logic             add_or_sub;
        logic [OFF_W-1:0] off_a;
        logic [OFF_W-1:0] off_b;
        logic [OFF_W-1:0] off_w;
    } ntt_cmd_t;

    localparam int CMD_W = $bits(ntt_cmd_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ntt_mem_sequencer_if.sv
// ntt_mem_sequencer_if: link between the sequencer and the ntt_processor.
//
// Handshake: the sequencer (master) raises ntt_start for exactly one cycle
// to launch a command and keeps ntt_mode/ntt_add_or_sub/ntt_off_* stable
// until the processor (slave) answers with ntt_finish, which is only
// honoured while a command is in flight. Memory traffic is unhandshaked:
// ntt_r_data follows ntt_r_addr with one cycle of latency, and a write
// happens on every cycle where ntt_w_en is high.
interface ntt_mem_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 96
);
    logic              ntt_start;
    logic [1:0]        ntt_mode;
    logic              ntt_add_or_sub;
    logic [8:0]        ntt_off_a;
    logic [8:0]        ntt_off_b;
    logic [8:0]        ntt_off_w;
    logic              ntt_finish;
    logic [ADDR_W-1:0] ntt_r_addr;
    logic [DATA_W-1:0] ntt_r_data;
    logic [ADDR_W-1:0] ntt_w_addr;
    logic [DATA_W-1:0] ntt_w_data;
    logic              ntt_w_en;

    modport master (
        output ntt_start, ntt_mode, ntt_add_or_sub,
        output ntt_off_a, ntt_off_b, ntt_off_w,
        output ntt_r_data,
        input  ntt_finish, ntt_r_addr, ntt_w_addr, ntt_w_data, ntt_w_en
    );

    modport slave (
        input  ntt_start, ntt_mode, ntt_add_or_sub,
        input  ntt_off_a, ntt_off_b, ntt_off_w,
        input  ntt_r_data,
        output ntt_finish, ntt_r_addr, ntt_w_addr, ntt_w_data, ntt_w_en
    );
endinterface

// File: rtl/ntt_mem_sequencer_cmd_fifo.sv
// ntt_cmd_fifo: small synchronous FIFO for host commands.
// A pop in the same cycle as a push on a full FIFO frees the slot first,
// so the push is accepted. Pushes that cannot be stored are dropped.
module ntt_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/ntt_mem_sequencer.sv
// ntt_mem_sequencer: queues host commands, launches them on the
// ntt_processor one at a time and owns the polynomial RAM that the
// processor reads and writes. The host may load/unload the RAM only while
// the engine is idle with nothing queued.
// Optional build macro NTT_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts a command after 255 WAIT cycles and sets sticky timeout_err.
module ntt_mem_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_mode,
    input  logic               cmd_add_or_sub,
    input  logic [8:0]         cmd_off_a,
    input  logic [8:0]         cmd_off_b,
    input  logic [8:0]         cmd_off_w,
    output logic               cmd_ready,
    input  logic               host_we,
    input  logic               host_re,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic [DATA_W-1:0]  host_rdata,
    output logic               host_rvalid,
    output logic               host_ready,
    ntt_mem_sequencer_if.master proc,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output seq_state_t         state_dbg
);
    seq_state_t state;
    seq_state_t state_nxt;

    ntt_cmd_t                 cmd_in;
    ntt_cmd_t                 cmd_head;
    ntt_cmd_t                 cmd_held;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(CMD_DEPTH):0] fifo_count;
    logic                     start_c;
    logic                     done_c;

    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic              host_wr;
    logic              host_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [DATA_W-1:0] ram_wd;
    logic [DATA_W-1:0] r_data_q;

`ifdef NTT_SEQ_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       timeout_hit;
    logic       timeout_q;
`endif

    assign cmd_in = {cmd_mode, cmd_add_or_sub, cmd_off_a, cmd_off_b, cmd_off_w};

    ntt_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .din   (cmd_in),
        .dout  (cmd_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pop in the same cycle makes room, so a full FIFO can still accept.
    assign cmd_ready  = !fifo_full || fifo_pop;
    assign host_ready = (state == IDLE) && fifo_empty && !(cmd_valid && cmd_ready);
    assign busy       = (state != IDLE) || (fifo_count != '0);
    assign done       = done_c;
    assign state_dbg  = state;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: pop in IDLE, one-cycle start in ISSUE, wait for finish.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        start_c   = 1'b0;
        done_c    = 1'b0;
`ifdef NTT_SEQ_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                start_c   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (proc.ntt_finish) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef NTT_SEQ_TIMEOUT_EN
                else if (wd_cnt == 8'hFF) begin
                    done_c      = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Held command: captured at pop, stable through ISSUE and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_held <= '0;
        end else if (fifo_pop) begin
            cmd_held <= cmd_head;
        end
    end

    assign proc.ntt_start      = start_c;
    assign proc.ntt_mode       = cmd_held.mode;
    assign proc.ntt_add_or_sub = cmd_held.add_or_sub;
    assign proc.ntt_off_a      = cmd_held.off_a;
    assign proc.ntt_off_b      = cmd_held.off_b;
    assign proc.ntt_off_w      = cmd_held.off_w;
    assign proc.ntt_r_data     = r_data_q;

`ifdef NTT_SEQ_TIMEOUT_EN
    // Watchdog: cleared on the way into WAIT, counts every WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Write port is shared: the host wins, but it is only granted while the
    // engine is idle, so it never collides with a processor write.
    assign host_wr = host_we && host_ready;
    assign host_rd = host_re && host_ready;
    assign ram_we  = host_wr || proc.ntt_w_en;
    assign ram_wa  = host_wr ? host_addr  : proc.ntt_w_addr;
    assign ram_wd  = host_wr ? host_wdata : proc.ntt_w_data;

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_wa] <= ram_wd;
        end
    end

    // Registered read ports; a same-cycle write is seen on the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q    <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            r_data_q    <= ram[proc.ntt_r_addr];
            host_rvalid <= host_rd;
            if (host_rd) begin
                host_rdata <= ram[host_addr];
            end
        end
    end
endmodule

// File: tb/tb_ntt_mem_sequencer.sv
// tb_ntt_mem_sequencer: directed testbench for ntt_mem_sequencer.
// Inputs change just after the falling edge; outputs are checked there too,
// half a cycle away from the rising edge the DUT acts on.
module tb_ntt_mem_sequencer;
    import ntt_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_mode = 2'd0;
    logic        cmd_add_or_sub = 1'b0;
    logic [8:0]  cmd_off_a = 9'd0;
    logic [8:0]  cmd_off_b = 9'd0;
    logic [8:0]  cmd_off_w = 9'd0;
    logic        cmd_ready;
    logic        host_we = 1'b0;
    logic        host_re = 1'b0;
    logic [8:0]  host_addr = 9'd0;
    logic [95:0] host_wdata = '0;
    logic [95:0] host_rdata;
    logic        host_rvalid;
    logic        host_ready;
    logic        busy;
    logic        done;
    logic        timeout_err;
    seq_state_t  state_dbg;

    int n_vec  = 0;
    int n_miss = 0;
    int n_starts = 0;
    logic prev_start = 1'b0;
    logic [8:0] exp_q[$];

    ntt_mem_sequencer_if #(.ADDR_W(9), .DATA_W(96)) proc ();

    ntt_mem_sequencer #(
        .CMD_DEPTH (4),
        .ADDR_W    (9),
        .DATA_W    (96)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_mode       (cmd_mode),
        .cmd_add_or_sub (cmd_add_or_sub),
        .cmd_off_a      (cmd_off_a),
        .cmd_off_b      (cmd_off_b),
        .cmd_off_w      (cmd_off_w),
        .cmd_ready      (cmd_ready),
        .host_we        (host_we),
        .host_re        (host_re),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_rvalid    (host_rvalid),
        .host_ready     (host_ready),
        .proc           (proc),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .state_dbg      (state_dbg)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit: got no finish, expected finish before 200000");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic host_write(input logic [8:0] addr, input logic [95:0] data);
        host_we = 1'b1; host_addr = addr; host_wdata = data;
        step();
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [8:0] addr, input logic [95:0] exp, input string tag);
        host_re = 1'b1; host_addr = addr;
        step();
        host_re = 1'b0;
        check({tag, "_rvalid"}, host_rvalid, 1'b1);
        check({tag, "_rdata"}, host_rdata, exp);
        step();
        check({tag, "_rvalid_pulse"}, host_rvalid, 1'b0);
    endtask

    task automatic set_cmd(input logic [1:0] mode, input logic [8:0] a, input logic [8:0] w);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_add_or_sub = 1'b0;
        cmd_off_a = a; cmd_off_b = a + 9'd1; cmd_off_w = w;
    endtask

    task automatic wait_state_wait(input string tag);
        int n = 0;
        while (state_dbg != WAIT && n < 20) begin
            step();
            n++;
        end
        check(tag, state_dbg == WAIT, 1'b1);
    endtask

    // Scoreboard: every start must be a one-cycle pulse carrying the
    // offset of the oldest accepted command.
    always @(negedge clk) begin
        if (!rst && proc.ntt_start) begin
            n_starts++;
            check("start_one_cycle", prev_start, 1'b0);
            check("start_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("start_order_off_w", proc.ntt_off_w, exp_q.pop_front());
            end
        end
        prev_start = rst ? 1'b0 : proc.ntt_start;
    end

    // Stimulus.
    initial begin
        logic stable;
        proc.ntt_finish = 1'b0;
        proc.ntt_r_addr = '0;
        proc.ntt_w_addr = '0;
        proc.ntt_w_data = '0;
        proc.ntt_w_en   = 1'b0;

        // Reset values
        step(); step();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_host_ready", host_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_start", proc.ntt_start, 1'b0);
        check("rst_rvalid", host_rvalid, 1'b0);
        check("rst_r_data", proc.ntt_r_data, 96'd0);
        check("rst_off_w", proc.ntt_off_w, 9'd0);
        check("rst_timeout", timeout_err, 1'b0);
        rst = 1'b0;
        step();

        // Host load and readback, plus write-with-read returning old data
        host_write(9'd5, 96'h0ABC);
        host_read(9'd5, 96'h0ABC, "host_rd5");
        host_write(9'd6, 96'h1111_2222_3333);
        host_we = 1'b1; host_re = 1'b1; host_addr = 9'd6; host_wdata = 96'h4444;
        step();
        host_we = 1'b0; host_re = 1'b0;
        check("host_rw_rvalid", host_rvalid, 1'b1);
        check("host_rw_old", host_rdata, 96'h1111_2222_3333);
        step();
        host_read(9'd6, 96'h4444, "host_rw_new");

        // Processor port: read-during-write returns old, then new data
        host_write(9'd40, 96'h00AA_0055);
        proc.ntt_w_en = 1'b1; proc.ntt_w_addr = 9'd40;
        proc.ntt_w_data = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
        proc.ntt_r_addr = 9'd40;
        step();
        proc.ntt_w_en = 1'b0;
        check("proc_rdw_old", proc.ntt_r_data, 96'h00AA_0055);
        step();
        check("proc_rd40", proc.ntt_r_data, 96'hDEAD_BEEF_0123_4567_89AB_CDEF);
        host_read(9'd40, 96'hDEAD_BEEF_0123_4567_89AB_CDEF, "host_rd40");

        // Single NTT command: start 2 cycles after push, offsets held
        exp_q.push_back(9'd32);
        set_cmd(MODE_NTT, 9'd0, 9'd32);
        #1;
        check("push_cmd_ready", cmd_ready, 1'b1);
        check("push_host_ready", host_ready, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("start_lat1", proc.ntt_start, 1'b0);
        check("busy_after_push", busy, 1'b1);
        step();
        check("start_lat2", proc.ntt_start, 1'b1);
        check("issue_mode", proc.ntt_mode, MODE_NTT);
        check("issue_off_b", proc.ntt_off_b, 9'd1);
        step();
        check("start_drop", proc.ntt_start, 1'b0);
        host_we = 1'b1; host_addr = 9'd5; host_wdata = 96'hFFF;
        #1;
        check("busy_host_ready", host_ready, 1'b0);
        step();
        host_we = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 220; i++) begin
            if (proc.ntt_off_w !== 9'd32 || proc.ntt_start !== 1'b0 ||
                done !== 1'b0 || busy !== 1'b1) stable = 1'b0;
            step();
        end
        check("held_stable", stable, 1'b1);
        proc.ntt_finish = 1'b1;
        #1;
        check("finish_done", done, 1'b1);
        step();
        proc.ntt_finish = 1'b0;
        check("done_pulse", done, 1'b0);
        check("busy_drop", busy, 1'b0);
        check("idle_host_ready", host_ready, 1'b1);
        check("idle_state", state_dbg, IDLE);
        proc.ntt_finish = 1'b1;
        #1;
        check("finish_in_idle", done, 1'b0);
        step();
        proc.ntt_finish = 1'b0;
        check("idle_after_stray", state_dbg, IDLE);
        check("no_timeout", timeout_err, 1'b0);
        host_read(9'd5, 96'h0ABC, "busy_wr_ignored");

        // Six back-to-back pushes with finish withheld: 1 in flight + 4 queued
        for (int k = 0; k < 6; k++) begin
            set_cmd(MODE_MULT, 9'(k), 9'(100 + k));
            #1;
            check($sformatf("fill_cmd_ready_%0d", k), cmd_ready, (k < 5));
            if (k < 5) exp_q.push_back(9'(100 + k));
            step();
        end
        cmd_valid = 1'b0;
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_state_wait($sformatf("drain_wait_%0d", i));
            proc.ntt_finish = 1'b1;
            #1;
            check($sformatf("drain_done_%0d", i), done, 1'b1);
            step();
            proc.ntt_finish = 1'b0;
            check($sformatf("b2b_gap_%0d", i), proc.ntt_start, 1'b0);
            step();
            check($sformatf("b2b_start_%0d", i), proc.ntt_start, (i < 4));
        end
        step(); step();
        check("drain_busy", busy, 1'b0);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_starts", n_starts, 6);

        // Reset while WAIT with one command still queued
        exp_q.push_back(9'd200);
        set_cmd(MODE_ADDSUB, 9'd7, 9'd200);
        step();
        exp_q.push_back(9'd201);
        set_cmd(MODE_INTT, 9'd8, 9'd201);
        step();
        cmd_valid = 1'b0;
        wait_state_wait("rst_mid_wait");
        rst = 1'b1;
        #1;
        check("rstmid_start", proc.ntt_start, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_cmd_ready", cmd_ready, 1'b1);
        check("rstmid_host_ready", host_ready, 1'b1);
        check("rstmid_off_w", proc.ntt_off_w, 9'd0);
        check("rstmid_state", state_dbg, IDLE);
        exp_q.delete();
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("rstmid_flushed", busy, 1'b0);
        check("rstmid_starts", n_starts, 7);

`ifdef NTT_SEQ_TIMEOUT_EN
        // Watchdog: withhold finish until the sequencer gives up
        begin
            int n = 0;
            logic seen_done = 1'b0;
            exp_q.push_back(9'd300);
            set_cmd(MODE_NTT, 9'd3, 9'd300);
            step();
            cmd_valid = 1'b0;
            while (!seen_done && n < 400) begin
                #1;
                if (done) seen_done = 1'b1;
                step();
                n++;
            end
            check("timeout_done", seen_done, 1'b1);
            check("timeout_err", timeout_err, 1'b1);
            check("timeout_idle", state_dbg, IDLE);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
